dcache_harness_bridge: RTL and testbench
========================================

// Module: dcache_harness_bridge
// PURPOSE
// - Parametrised bridge between the pipeline's flattened dcache request/response signals and a
//   Verilator test harness that may stall.
// - Buffers requests in a FIFO, bounds in-flight requests, registers responses, and flags
//   protocol errors.
// - Replaces the software reset-PC poke with a hardware boot-redirect sequencer.
// - Sits between the pipeline wrapper and the C++ memory model.
// PARAMETERS
// XLEN             64          data/address width
// FIFO_DEPTH       4           request FIFO entries; power of two, >=2
// MAX_OUTSTANDING  8           max accepted-but-unanswered requests, 1..255
// BOOT_DELAY       4           cycles after reset before redirect pulse, >=1
// RESET_PC         64'h8000_0000  boot redirect target
// PORTS
// clk_i            in   1     clock
// rst_ni           in   1     async active-low reset
// p_req_valid      in   1     pipeline request valid
// p_req_ready      out  1     bridge can accept request
// p_req_payload    in   P     {address,value,op,size,unsigned,amo[6:0],prv,sum,mxr,atp}, P=3*XLEN+ $bits(mem_op_e)+13
// p_resp_valid     out  1     registered response valid to pipeline
// p_resp_value     out  XLEN  registered response data
// p_ex_valid       out  1     registered exception valid
// p_ex_exception   out  exception_t  registered exception
// h_req_valid      out  1     FIFO head valid to harness
// h_req_ready      in   1     harness pops head
// h_req_payload    out  P     FIFO head payload
// h_resp_valid     in   1     harness response (no backpressure)
// h_resp_value     in   XLEN  harness response data
// h_ex_valid       in   1     harness exception
// h_ex_exception   in   exception_t  harness exception payload
// redirect_valid_o out  1     one-cycle boot redirect to frontend
// redirect_pc_o    out  XLEN  boot target, constant RESET_PC
// outstanding_o    out  8     current in-flight count
// err_o            out  1     sticky protocol-error flag
// BEHAVIOUR
// - Reset state: all valids 0, p_req_ready 0, FIFO empty, outstanding_o 0, err_o 0,
//   FSM in BOOT_WAIT, p_resp_value/p_ex_exception 0.
// - Boot FSM: BOOT_WAIT counts BOOT_DELAY cycles.
//   - BOOT_WAIT -> BOOT_REDIR: redirect_valid_o=1 for exactly one cycle.
//   - BOOT_REDIR -> RUN. RUN is terminal until reset.
// - p_req_ready = (state==RUN) & !fifo_full & (outstanding_o < MAX_OUTSTANDING).
//   Combinational; it must not depend on p_req_valid.
// - Accept: when p_req_valid & p_req_ready, the payload is written to the FIFO tail.
// - h_req_valid/h_req_payload are driven from registered FIFO state. An accepted request is
//   visible at h_req_valid the next cycle.
// - Pop: when h_req_valid & h_req_ready, the head is removed.
//   - Push and pop in the same cycle are legal when full: occupancy is unchanged, but
//     p_req_ready is still 0 when full.
//   - Push and pop in the same cycle are legal when empty: the push occurs and no pop occurs.
// - Pointers are log2(FIFO_DEPTH)+1 bits. Wrap is natural; full = MSBs differ and LSBs equal.
// - outstanding_o: +1 on accept, -1 on a completion (h_resp_valid | h_ex_valid).
//   - Accept and completion in the same cycle: net 0.
// - Response path:
//   - p_resp_valid <= h_resp_valid & !h_ex_valid.
//   - p_ex_valid <= h_ex_valid.
//   - Data is registered alongside its valid, so latency is 1 cycle.
//   - Data registers update only when the corresponding valid is high.
// - Errors that set err_o (sticky until reset):
//   - h_resp_valid & h_ex_valid in the same cycle: the exception is forwarded, counted as
//     one completion.
//   - A completion while outstanding_o==0 (and no same-cycle accept): the completion is
//     dropped (not forwarded), and the counter does not go below 0.
// - Async reset mid-operation: the FIFO is discarded, the counter cleared, the FSM restarts
//   at BOOT_WAIT, and a fresh redirect pulse follows.
// - No combinational path from h_* inputs to p_* outputs. The only combinational path is
//   h_req_ready -> none; p_req_ready depends on registered state only.
// TESTING
// - Reset, idle: redirect_valid_o pulses 1 cycle at cycle BOOT_DELAY+1 after rst_ni rises,
//   with redirect_pc_o=64'h8000_0000.
//   p_req_ready=0 before RUN and 1 after.
// - Harness stalls (h_req_ready=0), 5 back-to-back requests, FIFO_DEPTH=4:
//   - 4 are accepted; p_req_ready=0 on the 5th.
//   - Releasing the stall pops them in order; address 0x100,0x108,0x110,0x118.
// - MAX_OUTSTANDING=2, harness pops immediately and withholds responses: p_req_ready drops
//   after 2 accepts. One h_resp_valid with value 0xDEAD leads to:
//   - p_resp_valid=1 with p_resp_value=0xDEAD next cycle;
//   - outstanding_o=1;
//   - p_req_ready=1.
// - Accept and response in the same cycle at outstanding_o=1 -> outstanding_o stays 1,
//   err_o stays 0.
// - h_resp_valid with outstanding_o=0 -> no p_resp_valid, err_o=1 and stays 1.
//   h_resp_valid&h_ex_valid together -> p_ex_valid=1, p_resp_valid=0, err_o=1.
// - Assert rst_ni=0 with 3 FIFO entries and outstanding_o=3 -> all outputs return to reset
//   values immediately; after release, the boot pulse repeats and no stale h_req_valid
//   appears.

Source files
------------

// File: rtl/dcache_harness_bridge.sv
// Bridge between the pipeline's flattened dcache port and a stallable test harness:
// request FIFO, in-flight limit, registered responses, protocol error flag, boot redirect.
package dcache_harness_bridge_pkg;
   typedef enum logic [3:0] {
      MEM_LOAD  = 4'd0,
      MEM_STORE = 4'd1,
      MEM_AMO   = 4'd2,
      MEM_LR    = 4'd3,
      MEM_SC    = 4'd4,
      MEM_FENCE = 4'd5
   } mem_op_e;

   typedef struct packed {
      logic        valid;
      logic [63:0] cause;
      logic [63:0] tval;
   } exception_t;
endpackage

module dcache_harness_bridge
   import dcache_harness_bridge_pkg::*;
#(
   parameter int unsigned     XLEN            = 64,
   parameter int unsigned     FIFO_DEPTH      = 4,
   parameter int unsigned     MAX_OUTSTANDING = 8,
   parameter int unsigned     BOOT_DELAY      = 4,
   parameter logic [XLEN-1:0] RESET_PC        = 64'h8000_0000,
   localparam int unsigned    P               = 3*XLEN + $bits(mem_op_e) + 13
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             p_req_valid,
   output logic             p_req_ready,
   input  logic [P-1:0]     p_req_payload,
   output logic             p_resp_valid,
   output logic [XLEN-1:0]  p_resp_value,
   output logic             p_ex_valid,
   output exception_t       p_ex_exception,
   output logic             h_req_valid,
   input  logic             h_req_ready,
   output logic [P-1:0]     h_req_payload,
   input  logic             h_resp_valid,
   input  logic [XLEN-1:0]  h_resp_value,
   input  logic             h_ex_valid,
   input  exception_t       h_ex_exception,
   output logic             redirect_valid_o,
   output logic [XLEN-1:0]  redirect_pc_o,
   output logic [7:0]       outstanding_o,
   output logic             err_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(BOOT_DELAY + 1);
   localparam logic [AW:0]   PTR_ONE   = 1;
   localparam logic [CW-1:0] CNT_ONE   = 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(BOOT_DELAY - 1);
   localparam logic [7:0]    OUT_ONE   = 8'd1;
   localparam logic [7:0]    OUT_LIMIT = 8'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {
      BOOT_WAIT  = 2'd0,
      BOOT_REDIR = 2'd1,
      RUN        = 2'd2
   } boot_state_e;

   boot_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [P-1:0]  mem_q [FIFO_DEPTH];
   logic [AW:0]   wptr_q, rptr_q;
   logic          fifo_empty, fifo_full;
   logic          push, pop;

   logic [7:0]    out_q, out_d;
   logic          completion, drop, retire;
   logic          resp_fwd, ex_fwd;

   // Boot sequencer: BOOT_DELAY cycles of wait, one redirect cycle, then RUN forever.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= BOOT_WAIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      redirect_valid_o = 1'b0;
      unique case (state_q)
         BOOT_WAIT: begin
            if (cnt_q == CNT_LAST) state_d = BOOT_REDIR;
            else                   cnt_d   = cnt_q + CNT_ONE;
         end
         BOOT_REDIR: begin
            redirect_valid_o = 1'b1;
            state_d          = RUN;
         end
         RUN:     state_d = RUN;
         default: state_d = BOOT_WAIT;
      endcase
   end

   assign redirect_pc_o = RESET_PC;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign fifo_empty = (wptr_q == rptr_q);
   assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   assign p_req_ready   = (state_q == RUN) && !fifo_full && (out_q < OUT_LIMIT);
   assign push          = p_req_valid && p_req_ready;
   assign h_req_valid   = !fifo_empty;
   assign h_req_payload = mem_q[rptr_q[AW-1:0]];
   assign pop           = h_req_valid && h_req_ready;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (push) begin
            mem_q[wptr_q[AW-1:0]] <= p_req_payload;
            wptr_q                <= wptr_q + PTR_ONE;
         end
         if (pop) rptr_q <= rptr_q + PTR_ONE;
      end
   end

   // A completion with nothing in flight is dropped unless it pairs with a same-cycle accept.
   assign completion = h_resp_valid || h_ex_valid;
   assign drop       = completion && (out_q == '0) && !push;
   assign retire     = completion && !drop;
   assign resp_fwd   = h_resp_valid && !h_ex_valid && !drop;
   assign ex_fwd     = h_ex_valid && !drop;

   always_comb begin
      out_d = out_q;
      unique case ({push, retire})
         2'b10:   out_d = out_q + OUT_ONE;
         2'b01:   out_d = out_q - OUT_ONE;
         default: out_d = out_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_q          <= '0;
         err_o          <= 1'b0;
         p_resp_valid   <= 1'b0;
         p_resp_value   <= '0;
         p_ex_valid     <= 1'b0;
         p_ex_exception <= '0;
      end else begin
         out_q        <= out_d;
         p_resp_valid <= resp_fwd;
         p_ex_valid   <= ex_fwd;
         if (resp_fwd) p_resp_value   <= h_resp_value;
         if (ex_fwd)   p_ex_exception <= h_ex_exception;
         if ((h_resp_valid && h_ex_valid) || drop) err_o <= 1'b1;
      end
   end

   assign outstanding_o = out_q;

endmodule

// File: tb/tb_dcache_harness_bridge.sv
// Directed bench for dcache_harness_bridge: default instance plus a MAX_OUTSTANDING=2 instance.
module tb_dcache_harness_bridge;
   import dcache_harness_bridge_pkg::*;

   localparam int P = 3*64 + $bits(mem_op_e) + 13;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // instance a: default parameters
   logic         p_req_valid, p_req_ready, p_resp_valid, p_ex_valid;
   logic [P-1:0] p_req_payload, h_req_payload;
   logic [63:0]  p_resp_value, h_resp_value, redirect_pc;
   exception_t   p_ex_exception, h_ex_exception;
   logic         h_req_valid, h_req_ready, h_resp_valid, h_ex_valid, redirect_valid, err;
   logic [7:0]   outstanding;

   // instance b: MAX_OUTSTANDING = 2
   logic         p_req_valid_b, p_req_ready_b, p_resp_valid_b, p_ex_valid_b;
   logic [P-1:0] p_req_payload_b, h_req_payload_b;
   logic [63:0]  p_resp_value_b, h_resp_value_b, redirect_pc_b;
   exception_t   p_ex_exception_b, h_ex_exception_b;
   logic         h_req_valid_b, h_req_ready_b, h_resp_valid_b, h_ex_valid_b, redirect_valid_b, err_b;
   logic [7:0]   outstanding_b;

   dcache_harness_bridge dut (
      .clk_i(clk), .rst_ni(rst_n),
      .p_req_valid(p_req_valid), .p_req_ready(p_req_ready), .p_req_payload(p_req_payload),
      .p_resp_valid(p_resp_valid), .p_resp_value(p_resp_value),
      .p_ex_valid(p_ex_valid), .p_ex_exception(p_ex_exception),
      .h_req_valid(h_req_valid), .h_req_ready(h_req_ready), .h_req_payload(h_req_payload),
      .h_resp_valid(h_resp_valid), .h_resp_value(h_resp_value),
      .h_ex_valid(h_ex_valid), .h_ex_exception(h_ex_exception),
      .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
      .outstanding_o(outstanding), .err_o(err)
   );

   dcache_harness_bridge #(.MAX_OUTSTANDING(2)) dut_b (
      .clk_i(clk), .rst_ni(rst_n),
      .p_req_valid(p_req_valid_b), .p_req_ready(p_req_ready_b), .p_req_payload(p_req_payload_b),
      .p_resp_valid(p_resp_valid_b), .p_resp_value(p_resp_value_b),
      .p_ex_valid(p_ex_valid_b), .p_ex_exception(p_ex_exception_b),
      .h_req_valid(h_req_valid_b), .h_req_ready(h_req_ready_b), .h_req_payload(h_req_payload_b),
      .h_resp_valid(h_resp_valid_b), .h_resp_value(h_resp_value_b),
      .h_ex_valid(h_ex_valid_b), .h_ex_exception(h_ex_exception_b),
      .redirect_valid_o(redirect_valid_b), .redirect_pc_o(redirect_pc_b),
      .outstanding_o(outstanding_b), .err_o(err_b)
   );

   typedef struct {
      logic        acc;
      logic        rv;
      logic        ev;
      logic [63:0] val;
      logic [63:0] cause;
      logic        e_pv;
      logic        e_pex;
      logic [63:0] e_val;
      logic [63:0] e_cause;
      logic [7:0]  e_out;
      logic        e_err;
   } row_t;

   row_t rows [12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [P-1:0] mk_pl(input logic [63:0] addr);
      logic [P-1:0] pl;
      pl = '0;
      pl[P-1 -: 64]  = addr;
      pl[P-65 -: 64] = addr ^ 64'hA5A5_0000_0000_5A5A;
      return pl;
   endfunction

   task automatic chk_reset_values(input string tag);
      chk({tag, " p_req_ready"}, 64'(p_req_ready), 64'd0);
      chk({tag, " h_req_valid"}, 64'(h_req_valid), 64'd0);
      chk({tag, " p_resp_valid"}, 64'(p_resp_valid), 64'd0);
      chk({tag, " p_ex_valid"}, 64'(p_ex_valid), 64'd0);
      chk({tag, " p_resp_value"}, p_resp_value, 64'd0);
      chk({tag, " p_ex_cause"}, p_ex_exception.cause, 64'd0);
      chk({tag, " outstanding"}, 64'(outstanding), 64'd0);
      chk({tag, " err"}, 64'(err), 64'd0);
      chk({tag, " redirect_valid"}, 64'(redirect_valid), 64'd0);
   endtask

   // Release reset just after an edge; the pulse is expected after the 4th edge, RUN from the 5th.
   task automatic boot_check(input string tag);
      step();
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         chk($sformatf("%s redirect k=%0d", tag, k), 64'(redirect_valid), 64'(k == 4));
         chk($sformatf("%s ready k=%0d", tag, k), 64'(p_req_ready), 64'(k >= 5));
         chk($sformatf("%s stale hreq k=%0d", tag, k), 64'(h_req_valid), 64'd0);
         if (k == 4) chk({tag, " redirect_pc"}, redirect_pc, 64'h8000_0000);
      end
   endtask

   initial begin
      p_req_valid = 0; p_req_payload = '0; h_req_ready = 0;
      h_resp_valid = 0; h_resp_value = '0; h_ex_valid = 0; h_ex_exception = '0;
      p_req_valid_b = 0; p_req_payload_b = '0; h_req_ready_b = 0;
      h_resp_valid_b = 0; h_resp_value_b = '0; h_ex_valid_b = 0; h_ex_exception_b = '0;

      //            acc rv ev val          cause  pv pex e_val        e_cause out err
      rows[0]  = '{0, 1, 0, 64'h1111, 64'd0, 1, 0, 64'h1111, 64'd0, 8'd3, 0};
      rows[1]  = '{0, 0, 0, 64'h0,    64'd0, 0, 0, 64'h1111, 64'd0, 8'd3, 0};
      rows[2]  = '{0, 0, 1, 64'h0,    64'd5, 0, 1, 64'h1111, 64'd5, 8'd2, 0};
      rows[3]  = '{1, 1, 0, 64'h2222, 64'd0, 1, 0, 64'h2222, 64'd5, 8'd2, 0};
      rows[4]  = '{0, 1, 0, 64'h3333, 64'd0, 1, 0, 64'h3333, 64'd5, 8'd1, 0};
      rows[5]  = '{1, 1, 0, 64'h4444, 64'd0, 1, 0, 64'h4444, 64'd5, 8'd1, 0};
      rows[6]  = '{0, 1, 0, 64'h5555, 64'd0, 1, 0, 64'h5555, 64'd5, 8'd0, 0};
      rows[7]  = '{0, 1, 0, 64'h6666, 64'd0, 0, 0, 64'h5555, 64'd5, 8'd0, 1};
      rows[8]  = '{0, 0, 0, 64'h0,    64'd0, 0, 0, 64'h5555, 64'd5, 8'd0, 1};
      rows[9]  = '{0, 0, 1, 64'h0,    64'd9, 0, 0, 64'h5555, 64'd5, 8'd0, 1};
      rows[10] = '{1, 1, 0, 64'h7777, 64'd0, 1, 0, 64'h7777, 64'd5, 8'd0, 1};
      rows[11] = '{0, 0, 0, 64'h0,    64'd0, 0, 0, 64'h7777, 64'd5, 8'd0, 1};

      // reset state and first boot
      step();
      chk_reset_values("por");
      boot_check("boot1");

      // harness stalled: four accepts fill the FIFO, the fifth is refused
      h_req_ready = 0;
      for (int i = 0; i < 5; i++) begin
         p_req_payload = mk_pl(64'h100 + 64'(8*i));
         p_req_valid   = 1;
         chk($sformatf("stall ready i=%0d", i), 64'(p_req_ready), 64'(i < 4));
         step();
      end
      p_req_valid = 0;
      chk("stall outstanding", 64'(outstanding), 64'd4);
      chk("stall hreq_valid", 64'(h_req_valid), 64'd1);
      h_req_ready = 1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("pop valid i=%0d", i), 64'(h_req_valid), 64'd1);
         chk($sformatf("pop addr i=%0d", i), h_req_payload[P-1 -: 64], 64'h100 + 64'(8*i));
         chk($sformatf("pop value i=%0d", i), h_req_payload[P-65 -: 64],
             (64'h100 + 64'(8*i)) ^ 64'hA5A5_0000_0000_5A5A);
         step();
      end
      chk("drained hreq_valid", 64'(h_req_valid), 64'd0);

      // response / completion table, harness popping continuously
      for (int r = 0; r < 12; r++) begin
         p_req_valid              = rows[r].acc;
         p_req_payload            = mk_pl(64'h200 + 64'(r));
         h_resp_valid             = rows[r].rv;
         h_resp_value             = rows[r].val;
         h_ex_valid               = rows[r].ev;
         h_ex_exception           = '0;
         h_ex_exception.valid     = rows[r].ev;
         h_ex_exception.cause     = rows[r].cause;
         step();
         p_req_valid = 0; h_resp_valid = 0; h_ex_valid = 0;
         chk($sformatf("row%0d p_resp_valid", r), 64'(p_resp_valid), 64'(rows[r].e_pv));
         chk($sformatf("row%0d p_ex_valid", r), 64'(p_ex_valid), 64'(rows[r].e_pex));
         chk($sformatf("row%0d p_resp_value", r), p_resp_value, rows[r].e_val);
         chk($sformatf("row%0d p_ex_cause", r), p_ex_exception.cause, rows[r].e_cause);
         chk($sformatf("row%0d outstanding", r), 64'(outstanding), 64'(rows[r].e_out));
         chk($sformatf("row%0d err", r), 64'(err), 64'(rows[r].e_err));
      end

      // instance b: in-flight limit of two
      h_req_ready_b   = 1;
      p_req_valid_b   = 1;
      p_req_payload_b = mk_pl(64'h300);
      chk("b ready 0", 64'(p_req_ready_b), 64'd1);
      step();
      chk("b out 1", 64'(outstanding_b), 64'd1);
      chk("b ready 1", 64'(p_req_ready_b), 64'd1);
      p_req_payload_b = mk_pl(64'h308);
      step();
      chk("b out 2", 64'(outstanding_b), 64'd2);
      chk("b ready at limit", 64'(p_req_ready_b), 64'd0);
      step();
      p_req_valid_b = 0;
      chk("b out held", 64'(outstanding_b), 64'd2);
      chk("b popped", 64'(h_req_valid_b), 64'd0);
      h_resp_valid_b = 1; h_resp_value_b = 64'hDEAD;
      step();
      h_resp_valid_b = 0;
      chk("b resp valid", 64'(p_resp_valid_b), 64'd1);
      chk("b resp value", p_resp_value_b, 64'hDEAD);
      chk("b out after resp", 64'(outstanding_b), 64'd1);
      chk("b ready after resp", 64'(p_req_ready_b), 64'd1);
      chk("b err clean", 64'(err_b), 64'd0);
      h_resp_valid_b = 1; h_resp_value_b = 64'hBEEF;
      h_ex_valid_b = 1; h_ex_exception_b = '0;
      h_ex_exception_b.valid = 1; h_ex_exception_b.cause = 64'd9;
      step();
      h_resp_valid_b = 0; h_ex_valid_b = 0;
      chk("b both ex_valid", 64'(p_ex_valid_b), 64'd1);
      chk("b both resp_valid", 64'(p_resp_valid_b), 64'd0);
      chk("b both cause", p_ex_exception_b.cause, 64'd9);
      chk("b both resp value kept", p_resp_value_b, 64'hDEAD);
      chk("b both out", 64'(outstanding_b), 64'd0);
      chk("b both err", 64'(err_b), 64'd1);
      step();
      chk("b err sticky", 64'(err_b), 64'd1);

      // instance a: three queued, three in flight, then reset mid-operation
      h_req_ready = 0;
      for (int i = 0; i < 3; i++) begin
         p_req_valid   = 1;
         p_req_payload = mk_pl(64'h400 + 64'(8*i));
         step();
      end
      p_req_valid = 0;
      chk("pre-rst out", 64'(outstanding), 64'd3);
      chk("pre-rst hreq", 64'(h_req_valid), 64'd1);
      chk("pre-rst head", h_req_payload[P-1 -: 64], 64'h400);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_values("midrst");
      boot_check("boot2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
